// File: rtl/uart_tx_buffer.sv
// Byte FIFO between the UART controller transmit path and the serializer.
// First-word-fall-through read side, sticky overflow on writes while full.
module uart_tx_buffer #(
  parameter int DLEN  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_s_tvalid,
  output logic            o_s_tready,
  input  logic [DLEN-1:0] i_s_tdata,
  output logic            o_m_tvalid,
  input  logic            i_m_tready,
  output logic [DLEN-1:0] o_m_tdata,
  output logic            o_full,
  output logic            o_empty,
  output logic [AW:0]     o_count,
  output logic            o_overflow,
  input  logic            i_clr_overflow
);

  logic [DLEN-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            r_ovf;

  logic            w_push;
  logic            w_pop;

  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_overflow = r_ovf;

  // Ready gated by reset so nothing is accepted in the reset cycle.
  assign o_s_tready = rstn & ~o_full;
  assign o_m_tvalid = ~o_empty;
  assign o_m_tdata  = r_mem[r_rptr];

  assign w_push = i_s_tvalid & o_s_tready;
  assign w_pop  = o_m_tvalid & i_m_tready & rstn;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_s_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Set has priority over a coincident clear.
      if (i_s_tvalid & o_full) begin
        r_ovf <= 1'b1;
      end else if (i_clr_overflow) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rstn;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] s_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic [7:0] m_tdata;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       ovf;
  logic       clr;

  int checks = 0;
  int failures = 0;

  logic [7:0] mq[$];
  bit         movf;
  logic [7:0] dut_log[$];

  uart_tx_buffer #(.DLEN(8), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_s_tvalid     (s_tvalid),
    .o_s_tready     (s_tready),
    .i_s_tdata      (s_tdata),
    .o_m_tvalid     (m_tvalid),
    .i_m_tready     (m_tready),
    .o_m_tdata      (m_tdata),
    .o_full         (full),
    .o_empty        (empty),
    .o_count        (count),
    .o_overflow     (ovf),
    .i_clr_overflow (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  // Reference model: a plain queue of bytes plus a sticky bit.
  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (!rstn) begin
      mq.delete();
      movf = 0;
    end else begin
      do_push = s_tvalid && (mq.size() < DEPTH);
      do_pop  = m_tready && (mq.size() > 0);
      if (s_tvalid && mq.size() == DEPTH) movf = 1;
      else if (clr) movf = 0;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(s_tdata);
    end
  end

  always @(negedge clk) begin
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("m_tvalid", 32'(m_tvalid), 32'(mq.size() != 0));
    chk("s_tready", 32'(s_tready),
        32'(rstn === 1'b1 && mq.size() < DEPTH));
    chk("overflow", 32'(ovf), 32'(movf));
    if (mq.size() != 0) chk("m_tdata", 32'(m_tdata), 32'(mq[0]));
    if (rstn && m_tvalid && m_tready) dut_log.push_back(m_tdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [7:0] base);
    m_tready = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = base + 8'(i);
      tick();
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 64 && !empty; i++) tick();
    chk("drain_done", 32'(empty), 32'd1);
    m_tready = 1'b0;
  endtask

  task automatic chk_log(input string n, input int len,
                         input logic [7:0] base);
    chk({n, "_len"}, 32'(dut_log.size()), 32'(len));
    for (int i = 0; i < len && i < dut_log.size(); i++)
      chk(n, 32'(dut_log[i]), 32'(8'(base + 8'(i))));
  endtask

  initial begin
    rstn     = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 8'h77;
    m_tready = 1'b0;
    clr      = 1'b0;
    tick(); tick(); tick();
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rstn = 1'b1;
    #1;
    chk("rel_tready", 32'(s_tready), 32'd1);
    tick();
    s_tvalid = 1'b0;
    chk("first_push", 32'(count), 32'd1);
    chk("first_data", 32'(m_tdata), 32'h77);
    drain();
    dut_log.delete();

    push_n(16, 8'h00);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_tready", 32'(s_tready), 32'd0);
    drain();
    chk_log("fill_order", 16, 8'h00);
    dut_log.delete();

    push_n(16, 8'h20);
    s_tvalid = 1'b1;
    s_tdata  = 8'hA5;
    tick(); tick();
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    chk("ovf_pop_count", 32'(count), 32'd15);
    tick();
    s_tvalid = 1'b0;
    chk("ovf_a5_in", 32'(count), 32'd16);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);
    clr = 1'b1;
    s_tvalid = 1'b1;
    tick();
    clr = 1'b0;
    s_tvalid = 1'b0;
    chk("ovf_set_wins", 32'(ovf), 32'd1);
    drain();
    chk("ovf_log_len", 32'(dut_log.size()), 32'd17);
    if (dut_log.size() == 17) begin
      for (int i = 0; i < 16; i++)
        chk("ovf_order", 32'(dut_log[i]), 32'(8'h20 + 8'(i)));
      chk("ovf_last", 32'(dut_log[16]), 32'hA5);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    dut_log.delete();

    begin
      int idx = 0;
      int cyc = 0;
      while ((idx < 40 || !empty) && cyc < 600) begin
        s_tvalid = (idx < 40);
        s_tdata  = 8'h10 + 8'(idx);
        m_tready = 1'($urandom_range(0, 1));
        #1;
        if (s_tvalid && s_tready) idx++;
        tick();
        cyc++;
      end
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      chk("wrap_done", 32'(cyc < 600), 32'd1);
    end
    chk_log("wrap_order", 40, 8'h10);
    dut_log.delete();

    push_n(5, 8'h60);
    for (int i = 0; i < 20; i++) begin
      s_tvalid = 1'b1;
      m_tready = 1'b1;
      s_tdata  = 8'h65 + 8'(i);
      tick();
      chk("stream_count", 32'(count), 32'd5);
    end
    drain();
    chk_log("stream_order", 25, 8'h60);
    dut_log.delete();

    push_n(9, 8'h80);
    chk("mid_count9", 32'(count), 32'd9);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    push_n(1, 8'h5A);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    chk_log("mid_next", 1, 8'h5A);
    chk("mid_end_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
